tcp_flag_stats: RTL and testbench
=================================

Name: tcp_flag_stats

Overview:
Pipeline stage placed directly downstream of the TCP detection stage in the user data path.
- Passes every packet word through unmodified and in order.
- Parses the Ethernet/IPv4/TCP header words and counts TCP packets, non-TCP packets and SYN/FIN/RST segments.
- Exposes the counters as output ports for the register block.

Parameters:
DATA_WIDTH, 64, datapath width
CTRL_WIDTH, DATA_WIDTH/8, control width
CNT_WIDTH, 32, width of each statistics counter
FIFO_DEPTH_BITS, 3, log2 depth of input fallthrough_small_fifo_old

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_data  in  DATA_WIDTH  upstream packet data
in_ctrl  in  CTRL_WIDTH  upstream control (nonzero = module header or EOP byte mask)
in_wr  in  1  upstream write strobe
in_rdy  out  1  not-full of input FIFO
out_data  out  DATA_WIDTH  FIFO head data
out_ctrl  out  CTRL_WIDTH  FIFO head ctrl
out_wr  out  1  downstream write strobe
out_rdy  in  1  downstream ready
clear_stats  in  1  synchronous one-cycle clear of all counters
stat_tcp_pkts  out  CNT_WIDTH  IPv4 packets with protocol 6
stat_non_tcp  out  CNT_WIDTH  packets that are not IPv4/TCP
stat_syn  out  CNT_WIDTH  TCP segments with SYN set
stat_fin  out  CNT_WIDTH  TCP segments with FIN set
stat_rst  out  CNT_WIDTH  TCP segments with RST set
stat_ip_opt  out  CNT_WIDTH  TCP packets with IHL != 5 (flags not parsed)

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-high.
  - Reset clears all counters, the FIFO and the state machine (state = MOD_HDR).
  - out_wr = 0 during reset. Reset mid-packet discards that packet's remaining parse state.
- Transfer rule: xfer = !fifo_empty && out_rdy. out_wr = xfer and fifo rd_en = xfer, combinational.
  - out_data/out_ctrl are the FIFO head.
  - Zero added latency beyond the fallthrough FIFO.
  - Parsing advances only on xfer cycles.
- Word layout, word 1 is the first ctrl==0 word:
  - W2[31:16] ethertype; W2[15:12] version; W2[11:8] IHL.
  - W3[7:0] protocol.
  - W6[7:0] TCP flags: FIN bit0, SYN bit1, RST bit2.
- FSM (states MOD_HDR, W1, W2, W3, W4, W5, W6, PAYLOAD):
  - MOD_HDR: a word with ctrl != 0 stays in MOD_HDR; a word with ctrl == 0 goes to W2.
  - W2: ethertype != 16'h0800 or version != 4 → stat_non_tcp++ and go to PAYLOAD. Otherwise latch the IHL==5 flag and go to W3.
  - W3: protocol == 6 → stat_tcp_pkts++; if IHL != 5, also stat_ip_opt++ and go to PAYLOAD; else go to W4. Protocol != 6 → stat_non_tcp++ and go to PAYLOAD.
  - W4, W5: advance one state per transferred word.
  - W6: increment stat_syn/fin/rst per flag bits; several may increment in the same cycle. Then go to PAYLOAD.
  - PAYLOAD: a word with ctrl != 0 is EOP → MOD_HDR.
- Short packet: a ctrl != 0 word seen in any state W2..W6 is EOP.
  - Go to MOD_HDR and stop parsing; no flag counts.
  - EOP in W2 → stat_non_tcp++.
- Counter timing and width:
  - Counters update at the clock edge ending the xfer cycle of the deciding word.
  - Counters wrap modulo 2^CNT_WIDTH.
- clear_stats: zeroes all counters on the next edge. Simultaneous clear and increment → counter = 0 (clear wins).
- Backpressure: out_rdy low → no transfer, no state or counter change.
  - in_rdy = !fifo_full; writes when full are illegal upstream.

Decomposition:
- Shared package/include: ETH_TYPE_IP (16'h0800), IPV4 (4'h4), PROTO_TCP (8'h06), TCP flag bit indices, state one-hot encodings.
- Sub-module: reuse fallthrough_small_fifo_old as the input buffer.
- Counters: a tiny stat_counter sub-module (increment, clear, wrap) instantiated six times.

Test Plan:
- IPv4/TCP SYN packet, IHL=5, flags 8'h02, 8 words, out_rdy=1 → output identical word-for-word; stat_tcp_pkts=1, stat_syn=1, others 0.
- ARP packet (ethertype 16'h0806) then UDP packet (protocol 8'h11) → stat_non_tcp=2, TCP counters 0, both packets passed intact.
- TCP packet with flags 8'h05 (FIN+RST), out_rdy toggled 1/0 every cycle → stat_fin=1, stat_rst=1, stat_syn=0, no word lost or duplicated.
- TCP packet with IHL=6 → stat_tcp_pkts=1, stat_ip_opt=1, flag counters unchanged.
- clear_stats asserted in the same cycle as a W6 SYN xfer → stat_syn=0 afterward; the next SYN packet gives stat_syn=1.
- Reset asserted asynchronously mid-payload → out_wr=0 immediately, counters 0; the following clean TCP SYN packet is parsed correctly (stat_syn=1).

Source files
------------

// File: rtl/tcp_flag_stats_pkg.sv
`default_nettype none
// ============================================================================
// Package  : tcp_flag_stats_pkg
// Brief    : Header field constants, TCP flag bit positions and parser
//            state encodings shared by the TCP flag statistics stage.
// Revision : 1.0 - initial release
// ============================================================================
package tcp_flag_stats_pkg;

  localparam logic [15:0] ETH_TYPE_IP = 16'h0800;
  localparam logic [3:0]  IPV4        = 4'h4;
  localparam logic [3:0]  IHL_NO_OPT  = 4'h5;
  localparam logic [7:0]  PROTO_TCP   = 8'h06;

  // Bit positions inside the TCP flags byte
  localparam int FLAG_FIN = 0;
  localparam int FLAG_SYN = 1;
  localparam int FLAG_RST = 2;

  // One-hot parser states; W1 is consumed by the MOD_HDR -> W2 transition
  typedef enum logic [7:0] {
    MOD_HDR = 8'b0000_0001,
    W1      = 8'b0000_0010,
    W2      = 8'b0000_0100,
    W3      = 8'b0000_1000,
    W4      = 8'b0001_0000,
    W5      = 8'b0010_0000,
    W6      = 8'b0100_0000,
    PAYLOAD = 8'b1000_0000
  } state_e;

endpackage
`default_nettype wire

// File: rtl/tcp_flag_stats_counter.sv
`default_nettype none
// ============================================================================
// Module   : stat_counter
// Brief    : Wrapping statistics counter with synchronous clear; clear has
//            priority over a simultaneous increment.
// Revision : 1.0 - initial release
// ============================================================================
module stat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign count = cnt_q;

  // Next count: clear wins, otherwise increment modulo 2^WIDTH
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tcp_flag_stats_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fallthrough_small_fifo_old
// Brief    : Small first-word-fallthrough FIFO; the head word is visible on
//            dout whenever the FIFO is not empty.
// Revision : 1.0 - initial release
// ============================================================================
module fallthrough_small_fifo_old #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS-1:0] PTR_ONE   = {{(MAX_DEPTH_BITS-1){1'b0}}, 1'b1};
  localparam logic [MAX_DEPTH_BITS:0]   CNT_ONE   = {{MAX_DEPTH_BITS{1'b0}}, 1'b1};
  localparam logic [MAX_DEPTH_BITS:0]   CNT_FULL  = {1'b1, {MAX_DEPTH_BITS{1'b0}}};

  logic [WIDTH-1:0]          mem_q [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [MAX_DEPTH_BITS:0]   cnt_q, cnt_d;
  logic                      do_wr, do_rd;

  assign full  = (cnt_q == CNT_FULL);
  assign empty = (cnt_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // Pointer and occupancy update; overflow/underflow requests are ignored
  always_comb begin
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    wr_ptr_d = do_wr ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control registers, cleared by the asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array, no reset needed since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tcp_flag_stats.sv
`default_nettype none
// ============================================================================
// Module   : tcp_flag_stats
// Brief    : Pass-through stage that parses Ethernet/IPv4/TCP header words
//            and counts TCP, non-TCP, SYN, FIN, RST and IP-option packets.
// Revision : 1.0 - initial release
// ============================================================================
module tcp_flag_stats
  import tcp_flag_stats_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int CNT_WIDTH       = 32,
  parameter int FIFO_DEPTH_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic                  clear_stats,
  output logic [CNT_WIDTH-1:0]  stat_tcp_pkts,
  output logic [CNT_WIDTH-1:0]  stat_non_tcp,
  output logic [CNT_WIDTH-1:0]  stat_syn,
  output logic [CNT_WIDTH-1:0]  stat_fin,
  output logic [CNT_WIDTH-1:0]  stat_rst,
  output logic [CNT_WIDTH-1:0]  stat_ip_opt
);

  logic [CTRL_WIDTH+DATA_WIDTH-1:0] fifo_dout;
  logic   fifo_full, fifo_empty;
  logic   xfer, eop;
  state_e state_q, state_d;
  logic   ihl5_q, ihl5_d;
  logic   inc_tcp, inc_non, inc_syn, inc_fin, inc_rst, inc_opt;

  fallthrough_small_fifo_old #(
    .WIDTH          (CTRL_WIDTH + DATA_WIDTH),
    .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_in_fifo (
    .clk   (clk),
    .reset (reset),
    .din   ({in_ctrl, in_data}),
    .wr_en (in_wr),
    .rd_en (xfer),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_rdy              = !fifo_full;
  assign {out_ctrl, out_data} = fifo_dout;
  assign xfer                = !fifo_empty && out_rdy;
  assign out_wr              = xfer;
  assign eop                 = (out_ctrl != '0);

  // Header parser: advances one state per transferred word; a ctrl word in
  // W2..W6 marks a short packet and abandons parsing
  always_comb begin
    state_d = state_q;
    ihl5_d  = ihl5_q;
    inc_tcp = 1'b0;
    inc_non = 1'b0;
    inc_syn = 1'b0;
    inc_fin = 1'b0;
    inc_rst = 1'b0;
    inc_opt = 1'b0;
    if (xfer) begin
      case (state_q)
        MOD_HDR: begin
          if (!eop) state_d = W2;
        end
        W2: begin
          if (eop) begin
            inc_non = 1'b1;
            state_d = MOD_HDR;
          end else if ((out_data[31:16] != ETH_TYPE_IP) || (out_data[15:12] != IPV4)) begin
            inc_non = 1'b1;
            state_d = PAYLOAD;
          end else begin
            ihl5_d  = (out_data[11:8] == IHL_NO_OPT);
            state_d = W3;
          end
        end
        W3: begin
          if (eop) begin
            state_d = MOD_HDR;
          end else if (out_data[7:0] == PROTO_TCP) begin
            inc_tcp = 1'b1;
            if (!ihl5_q) begin
              inc_opt = 1'b1;
              state_d = PAYLOAD;
            end else begin
              state_d = W4;
            end
          end else begin
            inc_non = 1'b1;
            state_d = PAYLOAD;
          end
        end
        W4:      state_d = eop ? MOD_HDR : W5;
        W5:      state_d = eop ? MOD_HDR : W6;
        W6: begin
          if (eop) begin
            state_d = MOD_HDR;
          end else begin
            inc_fin = out_data[FLAG_FIN];
            inc_syn = out_data[FLAG_SYN];
            inc_rst = out_data[FLAG_RST];
            state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (eop) state_d = MOD_HDR;
        end
        default: state_d = MOD_HDR;
      endcase
    end
  end

  // Parser state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MOD_HDR;
      ihl5_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ihl5_q  <= ihl5_d;
    end
  end

  stat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_tcp (
    .clk(clk), .reset(reset), .clear(clear_stats), .inc(inc_tcp), .count(stat_tcp_pkts));
  stat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_non (
    .clk(clk), .reset(reset), .clear(clear_stats), .inc(inc_non), .count(stat_non_tcp));
  stat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_syn (
    .clk(clk), .reset(reset), .clear(clear_stats), .inc(inc_syn), .count(stat_syn));
  stat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_fin (
    .clk(clk), .reset(reset), .clear(clear_stats), .inc(inc_fin), .count(stat_fin));
  stat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_rst (
    .clk(clk), .reset(reset), .clear(clear_stats), .inc(inc_rst), .count(stat_rst));
  stat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_opt (
    .clk(clk), .reset(reset), .clear(clear_stats), .inc(inc_opt), .count(stat_ip_opt));

endmodule
`default_nettype wire

// File: tb/tb_tcp_flag_stats.sv
`default_nettype none
// ============================================================================
// Module   : tb_tcp_flag_stats
// Brief    : Self-checking bench for tcp_flag_stats with a packet-level
//            reference model and an output word scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tcp_flag_stats;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [63:0] data;
  } word_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;
  logic        clear_stats;
  logic [31:0] stat_tcp_pkts, stat_non_tcp, stat_syn, stat_fin, stat_rst, stat_ip_opt;

  word_t pkt_q[$];
  word_t exp_q[$];
  word_t mon_w;
  int    n_checks = 0;
  int    n_errors = 0;
  int    n_xfer   = 0;
  int    rdy_mode = 0;
  logic  rdy_force = 1'b0;
  int unsigned m_tcp, m_non, m_syn, m_fin, m_rst, m_opt;

  tcp_flag_stats dut (
    .clk           (clk),
    .reset         (reset),
    .in_data       (in_data),
    .in_ctrl       (in_ctrl),
    .in_wr         (in_wr),
    .in_rdy        (in_rdy),
    .out_data      (out_data),
    .out_ctrl      (out_ctrl),
    .out_wr        (out_wr),
    .out_rdy       (out_rdy),
    .clear_stats   (clear_stats),
    .stat_tcp_pkts (stat_tcp_pkts),
    .stat_non_tcp  (stat_non_tcp),
    .stat_syn      (stat_syn),
    .stat_fin      (stat_fin),
    .stat_rst      (stat_rst),
    .stat_ip_opt   (stat_ip_opt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_tcp"}, 72'(stat_tcp_pkts), 72'(m_tcp));
    check({tag, "_non"}, 72'(stat_non_tcp),  72'(m_non));
    check({tag, "_syn"}, 72'(stat_syn),      72'(m_syn));
    check({tag, "_fin"}, 72'(stat_fin),      72'(m_fin));
    check({tag, "_rst"}, 72'(stat_rst),      72'(m_rst));
    check({tag, "_opt"}, 72'(stat_ip_opt),   72'(m_opt));
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [7:0] eop_mask();
    return 8'(1 << $urandom_range(0, 7));
  endfunction

  // Downstream ready pattern: 0 always, 1 toggle, 2 random, else forced
  initial begin
    out_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = ~out_rdy;
        2:       out_rdy = 1'($urandom_range(0, 1));
        default: out_rdy = rdy_force;
      endcase
    end
  end

  // Output scoreboard: every transferred word must be the next word sent
  always @(negedge clk) begin
    if (out_wr) begin
      n_xfer++;
      if (exp_q.size() == 0) begin
        check("spurious_out_wr", 72'(1), 72'(0));
      end else begin
        mon_w = exp_q.pop_front();
        check("out_word", {out_ctrl, out_data}, mon_w);
      end
    end
  end

  // Packet-level classification following the header layout rules
  task automatic classify(output int tcp, output int non, output int syn,
                          output int fin, output int rst, output int opt);
    int   k;
    logic ihl5;
    tcp = 0; non = 0; syn = 0; fin = 0; rst = 0; opt = 0;
    k = 0;
    while (k < pkt_q.size() && pkt_q[k].ctrl != 8'h00) k++;
    k++;
    if (k >= pkt_q.size()) return;
    if (pkt_q[k].ctrl != 8'h00) begin non = 1; return; end
    if (pkt_q[k].data[31:16] != 16'h0800 || pkt_q[k].data[15:12] != 4'h4) begin
      non = 1;
      return;
    end
    ihl5 = (pkt_q[k].data[11:8] == 4'h5);
    k++;
    if (pkt_q[k].ctrl != 8'h00) return;
    if (pkt_q[k].data[7:0] != 8'h06) begin non = 1; return; end
    tcp = 1;
    if (!ihl5) begin opt = 1; return; end
    for (int j = k + 1; j <= k + 3; j++) begin
      if (pkt_q[j].ctrl != 8'h00) return;
    end
    k += 3;
    fin = int'(pkt_q[k].data[0]);
    syn = int'(pkt_q[k].data[1]);
    rst = int'(pkt_q[k].data[2]);
  endtask

  task automatic build_pkt(input logic [15:0] eth, input logic [3:0] ver, input logic [3:0] ihl,
                           input logic [7:0] proto, input logic [7:0] flags, input int n_pay);
    logic [63:0] r;
    pkt_q.delete();
    pkt_q.push_back({8'hFF, rnd64()});
    pkt_q.push_back({8'h00, rnd64()});
    pkt_q.push_back({8'h00, $urandom(), eth, ver, ihl, 8'($urandom())});
    r = rnd64(); r[7:0] = proto;
    pkt_q.push_back({8'h00, r});
    pkt_q.push_back({8'h00, rnd64()});
    pkt_q.push_back({8'h00, rnd64()});
    r = rnd64(); r[7:0] = flags;
    pkt_q.push_back({8'h00, r});
    repeat (n_pay) pkt_q.push_back({8'h00, rnd64()});
    pkt_q.push_back({eop_mask(), rnd64()});
  endtask

  task automatic send_word(input word_t w);
    int g = 0;
    while (!in_rdy && g < 1000) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 1000) check("in_rdy_timeout", 72'(in_rdy), 72'(1));
    exp_q.push_back(w);
    in_wr   = 1'b1;
    in_ctrl = w.ctrl;
    in_data = w.data;
    @(posedge clk); #1;
    in_wr   = 1'b0;
  endtask

  task automatic send_pkt();
    int tcp, non, syn, fin, rst, opt;
    classify(tcp, non, syn, fin, rst, opt);
    m_tcp += tcp; m_non += non; m_syn += syn;
    m_fin += fin; m_rst += rst; m_opt += opt;
    for (int i = 0; i < pkt_q.size(); i++) send_word(pkt_q[i]);
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 2000) begin
      @(posedge clk); #1;
      g++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 72'(exp_q.size()), 72'(0));
    @(posedge clk); #1;
  endtask

  task automatic zero_model();
    m_tcp = 0; m_non = 0; m_syn = 0; m_fin = 0; m_rst = 0; m_opt = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] w6;
    logic        cleared;
    int          base, g, nh, keep;
    logic [15:0] eth;
    logic [3:0]  ver, ihl;
    logic [7:0]  proto;

    reset = 1'b1; in_wr = 1'b0; in_data = '0; in_ctrl = '0; clear_stats = 1'b0;
    zero_model();
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_wr", 72'(out_wr), 72'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    check("reset_in_rdy", 72'(in_rdy), 72'(1));
    check_stats("reset");

    // SYN packet, continuous ready
    rdy_mode = 0;
    build_pkt(16'h0800, 4'h4, 4'h5, 8'h06, 8'h02, 0);
    send_pkt(); drain();
    check_stats("syn");
    check("syn_abs", 72'(stat_syn), 72'(1));

    // ARP then UDP
    build_pkt(16'h0806, 4'h4, 4'h5, 8'h06, 8'h02, 1);
    send_pkt();
    build_pkt(16'h0800, 4'h4, 4'h5, 8'h11, 8'h02, 2);
    send_pkt(); drain();
    check_stats("arp_udp");
    check("arp_udp_abs", 72'(stat_non_tcp), 72'(2));

    // FIN+RST with toggling ready
    rdy_mode = 1;
    build_pkt(16'h0800, 4'h4, 4'h5, 8'h06, 8'h05, 1);
    send_pkt(); drain();
    check_stats("finrst");

    // IP options: flags must be ignored
    rdy_mode = 0;
    build_pkt(16'h0800, 4'h4, 4'h6, 8'h06, 8'h07, 0);
    send_pkt(); drain();
    check_stats("ipopt");

    // Clear coinciding with the W6 transfer of a SYN packet
    rdy_mode = 3; rdy_force = 1'b0;
    build_pkt(16'h0800, 4'h4, 4'h5, 8'h06, 8'h02, 0);
    w6 = pkt_q[6].data;
    send_pkt();
    rdy_force = 1'b1;
    cleared = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #3;
      clear_stats = out_wr && (out_ctrl == 8'h00) && (out_data == w6);
      if (clear_stats) cleared = 1'b1;
    end
    clear_stats = 1'b0;
    check("clear_hit_w6", 72'(cleared), 72'(1));
    drain();
    zero_model();
    check_stats("clear");
    rdy_mode = 0;
    build_pkt(16'h0800, 4'h4, 4'h5, 8'h06, 8'h02, 3);
    send_pkt(); drain();
    check_stats("after_clear");
    check("after_clear_syn", 72'(stat_syn), 72'(1));

    // Asynchronous reset in the middle of the payload
    rdy_mode = 3; rdy_force = 1'b0;
    build_pkt(16'h0800, 4'h4, 4'h5, 8'h06, 8'h02, 1);
    void'(pkt_q.pop_back());
    send_pkt();
    base = n_xfer;
    rdy_force = 1'b1;
    g = 0;
    while (n_xfer < base + 7 && g < 100) begin
      @(posedge clk);
      g++;
    end
    check("rst_reach_payload", 72'(n_xfer - base), 72'(7));
    #3;
    reset = 1'b1;
    #1;
    check("rst_out_wr", 72'(out_wr), 72'(0));
    zero_model();
    check_stats("midreset");
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    rdy_mode = 0;
    build_pkt(16'h0800, 4'h4, 4'h5, 8'h06, 8'h02, 2);
    send_pkt(); drain();
    check_stats("post_reset");
    check("post_reset_syn", 72'(stat_syn), 72'(1));

    // Randomized packets, including short ones, under varied backpressure
    for (int p = 0; p < 40; p++) begin
      rdy_mode = $urandom_range(0, 2);
      eth   = ($urandom_range(0, 9) < 8) ? 16'h0800 : (($urandom_range(0, 1) == 1) ? 16'h0806 : 16'h86DD);
      ver   = ($urandom_range(0, 9) < 9) ? 4'h4 : 4'h6;
      ihl   = ($urandom_range(0, 4) == 0) ? 4'h6 : 4'h5;
      proto = ($urandom_range(0, 4) == 0) ? 8'h11 : 8'h06;
      build_pkt(eth, ver, ihl, proto, 8'($urandom()), $urandom_range(0, 4));
      nh = 1;
      if ($urandom_range(0, 2) == 0) begin
        pkt_q.push_front({8'hFF, rnd64()});
        nh = 2;
      end
      if ($urandom_range(0, 3) == 0) begin
        keep = nh + $urandom_range(1, 5);
        while (pkt_q.size() > keep) void'(pkt_q.pop_back());
        pkt_q.push_back({eop_mask(), rnd64()});
      end
      send_pkt(); drain();
      check_stats("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
